// File: rtl/atm_ctrl.sv
// ATM session controller: card lookup, PIN entry, and withdraw/deposit/query/exit on an internal account table.
// Optional per-account lockout after repeated wrong PINs is enabled by defining ATM_LOCKOUT_EN.
module atm_ctrl #(
  parameter int unsigned NUM_ACCTS = 4,
  parameter int unsigned CARD_W    = 32,
  parameter int unsigned PIN_W     = 20,
  parameter int unsigned BAL_W     = 16,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned CARD_BASE = 11112222,
  parameter int unsigned PIN_BASE  = 5432,
  parameter int unsigned INIT_BAL  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              card_valid,
  input  logic [CARD_W-1:0] cardnumber,
  input  logic              pin_valid,
  input  logic [PIN_W-1:0]  pin,
  input  logic              txn_valid,
  input  logic [2:0]        transaction,
  input  logic [BAL_W-1:0]  amount,
  output logic              busy,
  output logic              card_ok,
  output logic              card_err,
  output logic              pin_ok,
  output logic              pin_err,
  output logic              locked,
  output logic              txn_done,
  output logic              txn_err,
  output logic [2:0]        err_code,
  output logic [BAL_W-1:0]  balance
);

  localparam int unsigned IDX_W = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [2:0] TXN_WD   = 3'd1;
  localparam logic [2:0] TXN_DEP  = 3'd2;
  localparam logic [2:0] TXN_BAL  = 3'd3;
  localparam logic [2:0] TXN_EXIT = 3'd4;

  typedef enum logic [2:0] {IDLE, CARD_CHK, PIN_WAIT, MENU, EXEC} state_e;

  state_e             state_q, state_d;
  logic [CARD_W-1:0]  card_q, card_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [2:0]         txn_q, txn_d;
  logic [BAL_W-1:0]   amt_q, amt_d;
  logic [BAL_W-1:0]   bal_q [NUM_ACCTS];
  logic [BAL_W-1:0]   bal_d [NUM_ACCTS];
  logic [BAL_W-1:0]   balance_q, balance_d;
  logic [2:0]         err_code_q, err_code_d;
  logic card_ok_q, card_ok_d, card_err_q, card_err_d;
  logic pin_ok_q, pin_ok_d, pin_err_q, pin_err_d;
  logic txn_done_q, txn_done_d, txn_err_q, txn_err_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [BAL_W-1:0]   cur_bal;
  logic [BAL_W:0]     sum_w;
  logic               ex_done, ex_err, ex_upd;
  logic [2:0]         ex_code;
  logic [BAL_W-1:0]   ex_bal;

`ifdef ATM_LOCKOUT_EN
  logic [NUM_ACCTS-1:0] lock_q, lock_d;
  logic                 locked_q, locked_d;
`endif

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_ACCTS; i++) begin
      if (card_q == CARD_W'(CARD_BASE + i)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign cur_bal = bal_q[idx_q];
  assign sum_w   = {1'b0, cur_bal} + {1'b0, amt_q};

  always_comb begin
    state_d    = state_q;
    card_d     = card_q;
    idx_d      = idx_q;
    tries_d    = tries_q;
    txn_d      = txn_q;
    amt_d      = amt_q;
    bal_d      = bal_q;
    balance_d  = balance_q;
    err_code_d = err_code_q;
    card_ok_d  = 1'b0;
    card_err_d = 1'b0;
    pin_ok_d   = 1'b0;
    pin_err_d  = 1'b0;
    txn_done_d = 1'b0;
    txn_err_d  = 1'b0;
    ex_done    = 1'b0;
    ex_err     = 1'b0;
    ex_upd     = 1'b0;
    ex_code    = '0;
    ex_bal     = cur_bal;
`ifdef ATM_LOCKOUT_EN
    lock_d     = lock_q;
    locked_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && card_valid) begin
          card_d  = cardnumber;
          state_d = CARD_CHK;
        end
      end
      CARD_CHK: begin
        if (!start) begin
          state_d = IDLE;
        end else if (!hit) begin
          card_err_d = 1'b1;
          state_d    = IDLE;
        end
`ifdef ATM_LOCKOUT_EN
        else if (lock_q[hit_idx]) begin
          locked_d = 1'b1;
          state_d  = IDLE;
        end
`endif
        else begin
          card_ok_d = 1'b1;
          idx_d     = hit_idx;
          tries_d   = '0;
          state_d   = PIN_WAIT;
        end
      end
      PIN_WAIT: begin
        if (!start) begin
          state_d = IDLE;
        end else if (pin_valid) begin
          if (pin == PIN_W'(PIN_BASE + idx_q)) begin
            pin_ok_d = 1'b1;
            tries_d  = '0;
            state_d  = MENU;
          end else begin
            pin_err_d = 1'b1;
            if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
              tries_d = '0;
              state_d = IDLE;
`ifdef ATM_LOCKOUT_EN
              lock_d[idx_q] = 1'b1;
              locked_d      = 1'b1;
`endif
            end else begin
              tries_d = tries_q + TRY_W'(1);
            end
          end
        end
      end
      MENU: begin
        if (!start) begin
          state_d = IDLE;
        end else if (txn_valid) begin
          txn_d   = transaction;
          amt_d   = amount;
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (txn_q)
          TXN_WD: begin
            if (amt_q == '0) begin
              ex_err = 1'b1; ex_code = 3'd4;
            end else if (amt_q > cur_bal) begin
              ex_err = 1'b1; ex_code = 3'd1;
            end else begin
              ex_upd = 1'b1; ex_done = 1'b1; ex_bal = cur_bal - amt_q;
            end
          end
          TXN_DEP: begin
            if (amt_q == '0) begin
              ex_err = 1'b1; ex_code = 3'd4;
            end else if (sum_w[BAL_W]) begin
              ex_err = 1'b1; ex_code = 3'd2;
            end else begin
              ex_upd = 1'b1; ex_done = 1'b1; ex_bal = sum_w[BAL_W-1:0];
            end
          end
          TXN_BAL:  begin ex_upd = 1'b1; ex_done = 1'b1; end
          TXN_EXIT: ex_done = 1'b1;
          default:  begin ex_err = 1'b1; ex_code = 3'd3; end
        endcase
        // A dropped start still commits the balance; only the status pulses are suppressed.
        if (ex_upd) begin
          bal_d[idx_q] = ex_bal;
          balance_d    = ex_bal;
        end
        if (start) begin
          txn_done_d = ex_done;
          txn_err_d  = ex_err;
          err_code_d = ex_err ? ex_code : 3'd0;
        end
        state_d = (start && txn_q != TXN_EXIT) ? MENU : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      card_q     <= '0;
      idx_q      <= '0;
      tries_q    <= '0;
      txn_q      <= '0;
      amt_q      <= '0;
      balance_q  <= '0;
      err_code_q <= '0;
      card_ok_q  <= 1'b0;
      card_err_q <= 1'b0;
      pin_ok_q   <= 1'b0;
      pin_err_q  <= 1'b0;
      txn_done_q <= 1'b0;
      txn_err_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_ACCTS; i++) bal_q[i] <= BAL_W'(INIT_BAL);
    end else begin
      state_q    <= state_d;
      card_q     <= card_d;
      idx_q      <= idx_d;
      tries_q    <= tries_d;
      txn_q      <= txn_d;
      amt_q      <= amt_d;
      balance_q  <= balance_d;
      err_code_q <= err_code_d;
      card_ok_q  <= card_ok_d;
      card_err_q <= card_err_d;
      pin_ok_q   <= pin_ok_d;
      pin_err_q  <= pin_err_d;
      txn_done_q <= txn_done_d;
      txn_err_q  <= txn_err_d;
      bal_q      <= bal_d;
    end
  end

`ifdef ATM_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      locked_q <= locked_d;
    end
  end
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign busy     = (state_q != IDLE);
  assign card_ok  = card_ok_q;
  assign card_err = card_err_q;
  assign pin_ok   = pin_ok_q;
  assign pin_err  = pin_err_q;
  assign txn_done = txn_done_q;
  assign txn_err  = txn_err_q;
  assign err_code = err_code_q;
  assign balance  = balance_q;

endmodule
